ongorucu_erisim_hakemi: RTL and testbench
=========================================

ONGORUCU_ERISIM_HAKEMI -- requirements
Module: ongorucu_erisim_hakemi

Interface
REQ-001 SHALL have parameter KUYRUK_DERINLIK, default 4, update-queue depth (power of two, >=2).
REQ-002 SHALL have parameter ACLIK_SINIRI, default 3, max consecutive fetch grants while an update waits.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk_i input 1 (rising edge); rst_i input 1 (synchronous, active-high).
REQ-004 SHALL have getir_istek_i input 1, fetch lookup request.
REQ-005 SHALL have getir_ps_i input 32, fetch PC.
REQ-006 SHALL have getir_hazir_o output 1, fetch request accepted this cycle (combinational).
REQ-007 SHALL have yurut_gecerli_i input 1, resolved branch from execute.
REQ-008 SHALL have yurut_ps_i input 32, yurut_atladi_i input 1, yanlis_tahmin_i input 1: resolved branch PC, taken flag, mispredict flag.
REQ-009 SHALL have yurut_hazir_o output 1, queue can accept (= not full).
REQ-010 SHALL have tahmin_ps_gecerli_o output 1 and tahmin_ps_o output 32, registered lookup to predictor.
REQ-011 SHALL have yurut_ps_gecerli_o output 1, yurut_ps_o output 32, yurut_atladi_o output 1, yanlis_tahmin_o output 1, registered update to predictor.
REQ-012 SHALL have kuyruk_sayisi_o output clog2(KUYRUK_DERINLIK)+1, current queue occupancy.

Function
REQ-013 Execute entry SHALL be enqueued when yurut_gecerli_i && yurut_hazir_o; yurut_hazir_o = occupancy < KUYRUK_DERINLIK, so no enqueue when full even if a dequeue happens the same cycle.
REQ-014 Queue SHALL be FIFO; read/write pointers wrap modulo KUYRUK_DERINLIK; occupancy never exceeds depth or underflows.
REQ-015 Each cycle SHALL grant exactly one of: FETCH, UPDATE, or NONE; tahmin_ps_gecerli_o and yurut_ps_gecerli_o are never both 1.
REQ-016 UPDATE SHALL be granted when queue non-empty and any of: head has yanlis_tahmin set; queue full; aclik counter == ACLIK_SINIRI; getir_istek_i low.
REQ-017 Otherwise FETCH SHALL be granted if getir_istek_i; else NONE; getir_hazir_o = getir_istek_i && grant==FETCH.
REQ-018 On FETCH grant, next cycle tahmin_ps_gecerli_o=1, tahmin_ps_o=getir_ps_i; on UPDATE grant, next cycle yurut_ps_* outputs = head fields and head dequeued at that edge; ungranted valid output SHALL be 0 next cycle (single-cycle pulses).
REQ-019 Data outputs SHALL hold last value when their valid is 0.
REQ-020 aclik counter: increments (saturating at ACLIK_SINIRI) on FETCH grant with queue non-empty; clears on UPDATE grant or when queue empty.
REQ-021 Minimum update latency yurut_gecerli_i -> yurut_ps_gecerli_o SHALL be 2 cycles (no bypass); lookup latency 1 cycle.
REQ-022 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged and move both pointers.

Reset
REQ-023 While rst_i sampled high: all valid outputs 0, data outputs 0, pointers 0, occupancy 0, aclik counter 0; queued entries discarded mid-operation.
REQ-024 getir_hazir_o and yurut_hazir_o SHALL be 0 while rst_i is high.

Structure
REQ-025 Shared package SHALL hold PS width (32), default KUYRUK_DERINLIK/ACLIK_SINIRI, grant encoding (NONE/FETCH/UPDATE).
REQ-026 FIFO SHALL be a sub-module ongorucu_kuyrugu (34-bit entries: PS, atladi, yanlis_tahmin) with count output; arbiter and counter stay in top.

Verification
REQ-027 Fetch only, getir_ps_i=0x100 -> next cycle tahmin_ps_gecerli_o=1, tahmin_ps_o=0x100; yurut_ps_gecerli_o=0.
REQ-028 Continuous fetch, one update (PS=0x200, atladi=1, yanlis=0) enqueued -> fetch granted 3 cycles, 4th grant UPDATE, yurut_ps_o=0x200, getir_hazir_o=0 that cycle.
REQ-029 Continuous fetch, update with yanlis_tahmin=1 (PS=0x300) -> UPDATE granted first cycle after enqueue, yurut_ps_o=0x300 two cycles after yurut_gecerli_i.
REQ-030 4 updates back-to-back with fetch continuous -> occupancy 4, yurut_hazir_o=0, 5th yurut_gecerli_i not accepted, UPDATE granted until not full.
REQ-031 Reset asserted with 3 queued entries -> after reset kuyruk_sayisi_o=0, no yurut_ps_gecerli_o pulse for discarded entries.
REQ-032 Enqueue and dequeue same cycle at occupancy 2 -> occupancy stays 2, FIFO order preserved across pointer wrap.

Source files
------------

// File: rtl/ongorucu_erisim_hakemi_pkg.sv
// Shared types and defaults for the branch-predictor access arbiter.
package ongorucu_erisim_hakemi_pkg;

  localparam int PS_W = 32;
  localparam int VARSAYILAN_KUYRUK_DERINLIK = 4;
  localparam int VARSAYILAN_ACLIK_SINIRI = 3;

  typedef enum logic [1:0] {
    HAKEM_YOK      = 2'd0,
    HAKEM_GETIR    = 2'd1,
    HAKEM_GUNCELLE = 2'd2
  } hakem_t;

  typedef struct packed {
    logic [PS_W-1:0] ps;
    logic            atladi;
    logic            yanlis_tahmin;
  } kuyruk_girdi_t;

endpackage

// File: rtl/ongorucu_kuyrugu.sv
// Update FIFO holding resolved branches until the predictor port is free.
module ongorucu_kuyrugu
  import ongorucu_erisim_hakemi_pkg::*;
#(
  parameter int DERINLIK = VARSAYILAN_KUYRUK_DERINLIK
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       yaz_i,
  input  kuyruk_girdi_t              yazilan_i,
  input  logic                       oku_i,
  output kuyruk_girdi_t              bas_o,
  output logic [$clog2(DERINLIK):0]  sayi_o,
  output logic                       dolu_o,
  output logic                       bos_o
);

  localparam int IW = $clog2(DERINLIK);
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] DOLU_SAYI = SW'(DERINLIK);

  kuyruk_girdi_t   mem [DERINLIK];
  logic [IW-1:0]   yaz_ptr;
  logic [IW-1:0]   oku_ptr;
  logic [SW-1:0]   sayi;
  logic            yaz_ok;
  logic            oku_ok;

  // Guard internally as well so occupancy can never leave [0, DERINLIK].
  assign dolu_o = (sayi == DOLU_SAYI);
  assign bos_o  = (sayi == '0);
  assign yaz_ok = yaz_i && !dolu_o;
  assign oku_ok = oku_i && !bos_o;
  assign bas_o  = mem[oku_ptr];
  assign sayi_o = sayi;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else begin
      if (yaz_ok) yaz_ptr <= yaz_ptr + IW'(1);
      if (oku_ok) oku_ptr <= oku_ptr + IW'(1);
      case ({yaz_ok, oku_ok})
        2'b10:   sayi <= sayi + SW'(1);
        2'b01:   sayi <= sayi - SW'(1);
        default: sayi <= sayi;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz_ok) mem[yaz_ptr] <= yazilan_i;
  end

endmodule

// File: rtl/ongorucu_erisim_hakemi.sv
// Arbitrates the single predictor port between fetch lookups and queued updates.
module ongorucu_erisim_hakemi
  import ongorucu_erisim_hakemi_pkg::*;
#(
  parameter int KUYRUK_DERINLIK = VARSAYILAN_KUYRUK_DERINLIK,
  parameter int ACLIK_SINIRI    = VARSAYILAN_ACLIK_SINIRI
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              getir_istek_i,
  input  logic [PS_W-1:0]                   getir_ps_i,
  output logic                              getir_hazir_o,
  input  logic                              yurut_gecerli_i,
  input  logic [PS_W-1:0]                   yurut_ps_i,
  input  logic                              yurut_atladi_i,
  input  logic                              yanlis_tahmin_i,
  output logic                              yurut_hazir_o,
  output logic                              tahmin_ps_gecerli_o,
  output logic [PS_W-1:0]                   tahmin_ps_o,
  output logic                              yurut_ps_gecerli_o,
  output logic [PS_W-1:0]                   yurut_ps_o,
  output logic                              yurut_atladi_o,
  output logic                              yanlis_tahmin_o,
  output logic [$clog2(KUYRUK_DERINLIK):0]  kuyruk_sayisi_o
);

  localparam int AW = (ACLIK_SINIRI < 1) ? 1 : $clog2(ACLIK_SINIRI + 1);
  localparam logic [AW-1:0] ACLIK_UST = AW'(ACLIK_SINIRI);

  kuyruk_girdi_t  yeni_girdi;
  kuyruk_girdi_t  bas;
  logic           dolu;
  logic           bos;
  logic           yaz;
  logic           guncelle;
  logic [AW-1:0]  aclik_q;
  hakem_t         hakem;

  assign yurut_hazir_o = !rst_i && !dolu;
  assign yaz           = yurut_gecerli_i && yurut_hazir_o;
  assign yeni_girdi    = '{ps: yurut_ps_i, atladi: yurut_atladi_i, yanlis_tahmin: yanlis_tahmin_i};
  assign guncelle      = (hakem == HAKEM_GUNCELLE);
  assign getir_hazir_o = getir_istek_i && (hakem == HAKEM_GETIR);

  ongorucu_kuyrugu #(
    .DERINLIK (KUYRUK_DERINLIK)
  ) u_kuyruk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .yaz_i     (yaz),
    .yazilan_i (yeni_girdi),
    .oku_i     (guncelle),
    .bas_o     (bas),
    .sayi_o    (kuyruk_sayisi_o),
    .dolu_o    (dolu),
    .bos_o     (bos)
  );

  // Updates win on mispredict, full queue, starvation, or an idle fetch port.
  always_comb begin
    hakem = HAKEM_YOK;
    if (!rst_i) begin
      if (!bos && (bas.yanlis_tahmin || dolu || (aclik_q == ACLIK_UST) || !getir_istek_i))
        hakem = HAKEM_GUNCELLE;
      else if (getir_istek_i)
        hakem = HAKEM_GETIR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tahmin_ps_gecerli_o <= 1'b0;
      tahmin_ps_o         <= '0;
      yurut_ps_gecerli_o  <= 1'b0;
      yurut_ps_o          <= '0;
      yurut_atladi_o      <= 1'b0;
      yanlis_tahmin_o     <= 1'b0;
      aclik_q             <= '0;
    end else begin
      tahmin_ps_gecerli_o <= (hakem == HAKEM_GETIR);
      yurut_ps_gecerli_o  <= guncelle;
      if (hakem == HAKEM_GETIR) tahmin_ps_o <= getir_ps_i;
      if (guncelle) begin
        yurut_ps_o      <= bas.ps;
        yurut_atladi_o  <= bas.atladi;
        yanlis_tahmin_o <= bas.yanlis_tahmin;
      end
      if (guncelle || bos)
        aclik_q <= '0;
      else if ((hakem == HAKEM_GETIR) && (aclik_q != ACLIK_UST))
        aclik_q <= aclik_q + AW'(1);
    end
  end

endmodule

// File: tb/tb_ongorucu_erisim_hakemi.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_ongorucu_erisim_hakemi;
  import ongorucu_erisim_hakemi_pkg::*;

  localparam int D = 4;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        getir_istek_i;
  logic [31:0] getir_ps_i;
  logic        getir_hazir_o;
  logic        yurut_gecerli_i;
  logic [31:0] yurut_ps_i;
  logic        yurut_atladi_i;
  logic        yanlis_tahmin_i;
  logic        yurut_hazir_o;
  logic        tahmin_ps_gecerli_o;
  logic [31:0] tahmin_ps_o;
  logic        yurut_ps_gecerli_o;
  logic [31:0] yurut_ps_o;
  logic        yurut_atladi_o;
  logic        yanlis_tahmin_o;
  logic [2:0]  kuyruk_sayisi_o;

  int checks;
  int errors;

  kuyruk_girdi_t mq[$];
  int            m_aclik;
  logic          m_tv, m_yv, m_yat, m_yyan;
  logic [31:0]   m_tps, m_yps;

  always #5 clk = ~clk;

  ongorucu_erisim_hakemi #(
    .KUYRUK_DERINLIK (D),
    .ACLIK_SINIRI    (S)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .getir_istek_i       (getir_istek_i),
    .getir_ps_i          (getir_ps_i),
    .getir_hazir_o       (getir_hazir_o),
    .yurut_gecerli_i     (yurut_gecerli_i),
    .yurut_ps_i          (yurut_ps_i),
    .yurut_atladi_i      (yurut_atladi_i),
    .yanlis_tahmin_i     (yanlis_tahmin_i),
    .yurut_hazir_o       (yurut_hazir_o),
    .tahmin_ps_gecerli_o (tahmin_ps_gecerli_o),
    .tahmin_ps_o         (tahmin_ps_o),
    .yurut_ps_gecerli_o  (yurut_ps_gecerli_o),
    .yurut_ps_o          (yurut_ps_o),
    .yurut_atladi_o      (yurut_atladi_o),
    .yanlis_tahmin_o     (yanlis_tahmin_o),
    .kuyruk_sayisi_o     (kuyruk_sayisi_o)
  );

  task automatic compareVal(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    checks++;
    if (gercek !== beklenen) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic hakem_t modelGrant();
    if (rst_i) return HAKEM_YOK;
    if (mq.size() > 0 && (mq[0].yanlis_tahmin || mq.size() == D || m_aclik == S || !getir_istek_i))
      return HAKEM_GUNCELLE;
    if (getir_istek_i) return HAKEM_GETIR;
    return HAKEM_YOK;
  endfunction

  // Compares every observable output against the model for the current cycle.
  task automatic checkOutput();
    hakem_t g;
    g = modelGrant();
    compareVal("getir_hazir", getir_hazir_o, (getir_istek_i && g == HAKEM_GETIR));
    compareVal("yurut_hazir", yurut_hazir_o, (!rst_i && mq.size() < D));
    compareVal("kuyruk_sayisi", kuyruk_sayisi_o, mq.size());
    compareVal("tahmin_v", tahmin_ps_gecerli_o, m_tv);
    compareVal("tahmin_ps", tahmin_ps_o, m_tps);
    compareVal("yurut_v", yurut_ps_gecerli_o, m_yv);
    compareVal("yurut_ps", yurut_ps_o, m_yps);
    compareVal("yurut_atladi", yurut_atladi_o, m_yat);
    compareVal("yanlis_tahmin", yanlis_tahmin_o, m_yyan);
  endtask

  task automatic modelAdvance();
    hakem_t        g;
    kuyruk_girdi_t h;
    bit            bos_once;
    g = modelGrant();
    if (rst_i) begin
      mq.delete();
      m_aclik = 0;
      m_tv = 0; m_tps = 0; m_yv = 0; m_yps = 0; m_yat = 0; m_yyan = 0;
      return;
    end
    bos_once = (mq.size() == 0);
    m_tv = (g == HAKEM_GETIR);
    if (g == HAKEM_GETIR) m_tps = getir_ps_i;
    m_yv = (g == HAKEM_GUNCELLE);
    if (yurut_gecerli_i && mq.size() < D)
      mq.push_back('{ps: yurut_ps_i, atladi: yurut_atladi_i, yanlis_tahmin: yanlis_tahmin_i});
    if (g == HAKEM_GUNCELLE) begin
      h = mq.pop_front();
      m_yps = h.ps; m_yat = h.atladi; m_yyan = h.yanlis_tahmin;
    end
    if (g == HAKEM_GUNCELLE || bos_once) m_aclik = 0;
    else if (g == HAKEM_GETIR && m_aclik < S) m_aclik++;
  endtask

  task automatic applyStimulus(input logic r, input logic ist, input logic [31:0] ps,
                               input logic yv, input logic [31:0] yps, input logic yat, input logic yyan);
    @(negedge clk);
    rst_i = r; getir_istek_i = ist; getir_ps_i = ps;
    yurut_gecerli_i = yv; yurut_ps_i = yps; yurut_atladi_i = yat; yanlis_tahmin_i = yyan;
    #1;
  endtask

  task automatic cycleEnd();
    checkOutput();
    modelAdvance();
    @(posedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycleEnd();
    end
  endtask

  initial begin
    logic [3:0] haz;
    checks = 0; errors = 0;
    m_aclik = 0; m_tv = 0; m_tps = 0; m_yv = 0; m_yps = 0; m_yat = 0; m_yyan = 0;
    rst_i = 1; getir_istek_i = 0; getir_ps_i = 0;
    yurut_gecerli_i = 0; yurut_ps_i = 0; yurut_atladi_i = 0; yanlis_tahmin_i = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0); cycleEnd();
    applyStimulus(1, 1, 32'h44, 1, 32'h55, 0, 0);
    compareVal("rst_getir_hazir", getir_hazir_o, 0);
    compareVal("rst_yurut_hazir", yurut_hazir_o, 0);
    cycleEnd();

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    compareVal("reset_count", kuyruk_sayisi_o, 0);
    compareVal("reset_tahmin_v", tahmin_ps_gecerli_o, 0);
    compareVal("reset_yurut_hazir", yurut_hazir_o, 1);
    cycleEnd();

    // Plain lookup
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0);
    compareVal("fetch_hazir", getir_hazir_o, 1);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    compareVal("fetch_v", tahmin_ps_gecerli_o, 1);
    compareVal("fetch_ps", tahmin_ps_o, 32'h100);
    compareVal("fetch_no_upd", yurut_ps_gecerli_o, 0);
    cycleEnd();

    // Starvation limit forces the update on the fourth grant
    applyStimulus(0, 1, 32'h1000, 1, 32'h200, 1, 0); cycleEnd();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h1004 + 4 * i, 0, 0, 0, 0);
      haz[i] = getir_hazir_o;
      cycleEnd();
    end
    compareVal("starve_grants", {28'd0, haz}, 32'b0111);
    applyStimulus(0, 1, 32'h1020, 0, 0, 0, 0);
    compareVal("starve_upd_v", yurut_ps_gecerli_o, 1);
    compareVal("starve_upd_ps", yurut_ps_o, 32'h200);
    compareVal("starve_upd_atladi", yurut_atladi_o, 1);
    cycleEnd();

    // Mispredict jumps ahead of fetch
    applyStimulus(0, 1, 32'h2000, 1, 32'h300, 0, 1); cycleEnd();
    applyStimulus(0, 1, 32'h2004, 0, 0, 0, 0);
    compareVal("mis_getir_hazir", getir_hazir_o, 0);
    cycleEnd();
    applyStimulus(0, 1, 32'h2008, 0, 0, 0, 0);
    compareVal("mis_upd_v", yurut_ps_gecerli_o, 1);
    compareVal("mis_upd_ps", yurut_ps_o, 32'h300);
    compareVal("mis_upd_yanlis", yanlis_tahmin_o, 1);
    cycleEnd();

    // Fill the queue, then the fifth push must be refused
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h3000 + 4 * i, 1, 32'h400 + 4 * i, 0, 0);
      cycleEnd();
    end
    applyStimulus(0, 1, 32'h3010, 1, 32'h4F0, 0, 0);
    compareVal("full_count", kuyruk_sayisi_o, 4);
    compareVal("full_yurut_hazir", yurut_hazir_o, 0);
    compareVal("full_getir_hazir", getir_hazir_o, 0);
    cycleEnd();
    applyStimulus(0, 1, 32'h3014, 0, 0, 0, 0);
    compareVal("full_after_count", kuyruk_sayisi_o, 3);
    compareVal("full_after_ps", yurut_ps_o, 32'h400);
    cycleEnd();
    drain(4);

    // Reset discards queued entries
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h5000 + 4 * i, 1, 32'h600 + 4 * i, 0, 0);
      cycleEnd();
    end
    applyStimulus(1, 1, 32'h500C, 0, 0, 0, 0);
    compareVal("prereset_count", kuyruk_sayisi_o, 3);
    cycleEnd();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      compareVal("postreset_count", kuyruk_sayisi_o, 0);
      compareVal("postreset_no_upd", yurut_ps_gecerli_o, 0);
      cycleEnd();
    end

    // Concurrent push/pop at occupancy 2 across pointer wrap
    applyStimulus(0, 1, 32'h7000, 1, 32'h500, 0, 0); cycleEnd();
    applyStimulus(0, 1, 32'h7004, 1, 32'h504, 0, 0); cycleEnd();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h508 + 4 * i, 0, 0);
      compareVal("wrap_count", kuyruk_sayisi_o, 2);
      if (i > 0) compareVal("wrap_order", yurut_ps_o, 32'h500 + 4 * (i - 1));
      cycleEnd();
    end
    drain(4);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(199) == 0), ($urandom_range(9) < 8), $urandom,
                    ($urandom_range(1) == 1), $urandom, ($urandom_range(1) == 1),
                    ($urandom_range(4) == 0));
      cycleEnd();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
